// File: rtl/ikaopll_bus_writer_pkg.sv
// Shared types and constants for the IKAOPLL host-side bus write sequencer.
package ikaopll_bus_writer_pkg;

  // Sequencer phases for one (address, data) register write pair.
  typedef enum logic [2:0] {
    StIdle,
    StAStb,
    StAWait,
    StDStb,
    StDWait
  } state_e;

  // Default timing, counted in phiM enables.
  localparam int unsigned DefWrPulse  = 2;
  localparam int unsigned DefAddrWait = 12;
  localparam int unsigned DefDataWait = 84;

  // Bus levels while no write is in progress.
  localparam logic       BusCsIdle  = 1'b1;
  localparam logic       BusWrIdle  = 1'b1;
  localparam logic       BusA0Reset = 1'b0;
  localparam logic [7:0] BusDReset  = 8'h00;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ikaopll_bus_writer_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a pop frees its slot for a push on the same edge.
module ikaopll_bus_writer_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             ready,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             full;
  logic             push_ok, pop_ok;

  // Occupancy derives directly from the pointer registers, so it is a registered value.
  always_comb begin
    level   = wptr_q - rptr_q;
    full    = (level == (AW + 1)'(DEPTH));
    empty   = (level == '0);
    ready   = ~full;
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
    rdata   = mem[rptr_q[AW-1:0]];
  end

  // Pointer update; reset flushes the contents by aligning the pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + (AW + 1)'(1);
      if (pop_ok)  rptr_q <= rptr_q + (AW + 1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ikaopll_bus_writer.sv
// Replays queued (address, data) pairs as YM2413 address/data bus writes with chip wait times.
module ikaopll_bus_writer
  import ikaopll_bus_writer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned WR_PULSE   = DefWrPulse,
  parameter int unsigned ADDR_WAIT  = DefAddrWait,
  parameter int unsigned DATA_WAIT  = DefDataWait,
  localparam int unsigned LevelW    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              i_EMUCLK,
  input  logic              i_RST,
  input  logic              i_phiM_PCEN_n,
  input  logic              i_WR_VALID,
  output logic              o_WR_READY,
  input  logic [7:0]        i_WR_ADDR,
  input  logic [7:0]        i_WR_DATA,
  output logic              o_CS_n,
  output logic              o_WR_n,
  output logic              o_A0,
  output logic [7:0]        o_D,
  output logic              o_BUSY,
  output logic [LevelW-1:0] o_LEVEL
);

  localparam int unsigned CntMax = max3(WR_PULSE, ADDR_WAIT, DATA_WAIT);
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] PulseLd = CntW'(WR_PULSE);
  localparam logic [CntW-1:0] AddrLd  = CntW'(ADDR_WAIT);
  localparam logic [CntW-1:0] DataLd  = CntW'(DATA_WAIT);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [15:0]     hold_q;
  logic            cs_n_q, wr_n_q, a0_q;
  logic [7:0]      d_q;

  logic            fifo_empty, fifo_pop;
  logic [15:0]     fifo_rdata;
  logic            phim_en, cnt_last;

  // IDLE pops regardless of the phiM enable; only the timed phases wait for it.
  always_comb begin
    phim_en  = ~i_phiM_PCEN_n;
    cnt_last = (cnt_q <= CntW'(1));
    fifo_pop = (state_q == StIdle) & ~fifo_empty;
  end

  ikaopll_bus_writer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk   (i_EMUCLK),
    .rst   (i_RST),
    .push  (i_WR_VALID),
    .pop   (fifo_pop),
    .wdata ({i_WR_ADDR, i_WR_DATA}),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .ready (o_WR_READY),
    .level (o_LEVEL)
  );

  // Sequencer: bus outputs are registered and change only on the edge the strobe falls or rises.
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hold_q  <= '0;
      cs_n_q  <= BusCsIdle;
      wr_n_q  <= BusWrIdle;
      a0_q    <= BusA0Reset;
      d_q     <= BusDReset;
    end else begin
      case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            hold_q  <= fifo_rdata;
            state_q <= StAStb;
            cnt_q   <= PulseLd;
            cs_n_q  <= 1'b0;
            wr_n_q  <= 1'b0;
            a0_q    <= 1'b0;
            d_q     <= fifo_rdata[15:8];
          end
        end
        StAStb: begin
          if (phim_en) begin
            if (cnt_last) begin
              state_q <= StAWait;
              cnt_q   <= AddrLd;
              cs_n_q  <= BusCsIdle;
              wr_n_q  <= BusWrIdle;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
        end
        StAWait: begin
          if (phim_en) begin
            if (cnt_last) begin
              state_q <= StDStb;
              cnt_q   <= PulseLd;
              cs_n_q  <= 1'b0;
              wr_n_q  <= 1'b0;
              a0_q    <= 1'b1;
              d_q     <= hold_q[7:0];
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
        end
        StDStb: begin
          if (phim_en) begin
            if (cnt_last) begin
              state_q <= StDWait;
              cnt_q   <= DataLd;
              cs_n_q  <= BusCsIdle;
              wr_n_q  <= BusWrIdle;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
        end
        StDWait: begin
          if (phim_en) begin
            if (cnt_last) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output drive and busy flag.
  always_comb begin
    o_CS_n = cs_n_q;
    o_WR_n = wr_n_q;
    o_A0   = a0_q;
    o_D    = d_q;
    o_BUSY = (o_LEVEL != '0) | (state_q != StIdle);
  end

endmodule

// File: tb/tb_ikaopll_bus_writer.sv
// Randomised and directed bench for ikaopll_bus_writer against a timeline-based reference model.
module tb_ikaopll_bus_writer;

  localparam int unsigned Depth    = 4;
  localparam int unsigned WrPulse  = 2;
  localparam int unsigned AddrWait = 12;
  localparam int unsigned DataWait = 84;
  localparam int unsigned Total    = 2 * WrPulse + AddrWait + DataWait;

  logic       clk = 1'b0;
  logic       rst, pcen_n, wr_valid;
  logic [7:0] wr_addr, wr_data;
  logic       wr_ready, cs_n, wr_n, a0, busy;
  logic [7:0] d;
  logic [2:0] level;

  always #5 clk = ~clk;

  ikaopll_bus_writer #(
    .FIFO_DEPTH (Depth),
    .WR_PULSE   (WrPulse),
    .ADDR_WAIT  (AddrWait),
    .DATA_WAIT  (DataWait)
  ) dut (
    .i_EMUCLK      (clk),
    .i_RST         (rst),
    .i_phiM_PCEN_n (pcen_n),
    .i_WR_VALID    (wr_valid),
    .o_WR_READY    (wr_ready),
    .i_WR_ADDR     (wr_addr),
    .i_WR_DATA     (wr_data),
    .o_CS_n        (cs_n),
    .o_WR_n        (wr_n),
    .o_A0          (a0),
    .o_D           (d),
    .o_BUSY        (busy),
    .o_LEVEL       (level)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of pairs plus the number of enables elapsed since the current pop.
  logic [15:0] q[$];
  bit          m_active;
  int          m_n;
  logic [15:0] m_cur;
  logic        m_a0;
  logic [7:0]  m_d;
  bit          m_acc;
  int          mode;
  int          cyc;
  int          en_cnt;
  int          last_fall_en;
  bit          have_fall;
  int          gaps[$];
  logic        prev_cs;

  task automatic step();
    bit   pop_now;
    bit   strobe;
    logic e_cs;
    case (mode)
      0:       pcen_n = ((cyc % 4) != 3);
      1:       pcen_n = 1'b1;
      2:       pcen_n = 1'($urandom % 2);
      default: pcen_n = 1'b0;
    endcase
    cyc++;
    @(posedge clk);
    m_acc = 1'b0;
    if (rst) begin
      q.delete();
      m_active = 1'b0;
      m_n      = 0;
      m_a0     = 1'b0;
      m_d      = 8'h00;
    end else begin
      if (!pcen_n) en_cnt++;
      pop_now = !m_active && (q.size() > 0);
      m_acc   = wr_valid && ((q.size() < Depth) || pop_now);
      if (m_active && !pcen_n) begin
        m_n++;
        if (m_n == Total) m_active = 1'b0;
      end
      if (pop_now) begin
        m_cur    = q.pop_front();
        m_active = 1'b1;
        m_n      = 0;
      end
      if (m_acc) q.push_back({wr_addr, wr_data});
    end
    e_cs = 1'b1;
    if (m_active) begin
      strobe = (m_n < WrPulse) || ((m_n >= WrPulse + AddrWait) && (m_n < 2 * WrPulse + AddrWait));
      m_a0   = (m_n >= WrPulse + AddrWait);
      m_d    = m_a0 ? m_cur[7:0] : m_cur[15:8];
      e_cs   = !strobe;
    end
    #1;
    check("outputs", {17'd0, cs_n, wr_n, a0, d, wr_ready, busy, level},
          {17'd0, e_cs, e_cs, m_a0, m_d, (q.size() < Depth), (q.size() != 0 || m_active),
           3'(q.size())});
    if (prev_cs && !cs_n && !a0) begin
      if (have_fall) gaps.push_back(en_cnt - last_fall_en);
      have_fall    = 1'b1;
      last_fall_en = en_cnt;
    end
    prev_cs = cs_n;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] v);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = v;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int k = 0;
    while ((m_active || q.size() != 0) && k < budget) begin
      step();
      k++;
    end
    check(tag, busy, 0);
  endtask

  initial begin
    int k;
    int strobes;
    rst = 1'b1; pcen_n = 1'b1; wr_valid = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
    mode = 1; cyc = 0; en_cnt = 0; have_fall = 1'b0; prev_cs = 1'b1; last_fall_en = 0;
    m_active = 1'b0; m_n = 0; m_cur = '0; m_a0 = 1'b0; m_d = 8'h00;
    step();
    check("rst_cs", cs_n, 1);
    check("rst_wr", wr_n, 1);
    check("rst_a0", a0, 0);
    check("rst_d", d, 0);
    check("rst_ready", wr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    rst = 1'b0;

    // Single write with the enable low every 4th clock.
    mode = 0;
    push(8'h10, 8'h55);
    run_until_idle(2000, "single_done");

    // Back-to-back pairs: address strobes must be exactly Total enables apart.
    gaps.delete(); have_fall = 1'b0;
    push(8'h30, 8'h11);
    push(8'h20, 8'h1F);
    push(8'h0E, 8'h20);
    run_until_idle(3000, "b2b_done");
    check("b2b_gap_count", gaps.size(), 2);
    foreach (gaps[i]) check("b2b_gap", gaps[i], Total);

    // Fill with the sequencer stalled, then release while still pushing to hit push+pop at full.
    mode = 1;
    for (int i = 0; i < 6; i++) push(8'h40 + 8'(i), 8'h80 + 8'(i));
    check("full_ready", wr_ready, 0);
    check("full_level", level, Depth);
    mode = 0;
    wr_valid = 1'b1; wr_addr = 8'hA5; wr_data = 8'h5A;
    k = 0;
    do begin
      step();
      k++;
    end while (!m_acc && k < 2000);
    wr_valid = 1'b0;
    check("pushpop_full_level", level, Depth);
    run_until_idle(5000, "full_drain");

    // Reset while waiting after the address strobe: the data strobe must never appear.
    mode = 0;
    push(8'h42, 8'h99);
    k = 0;
    while (!(m_active && m_n >= WrPulse && m_n < WrPulse + AddrWait) && k < 200) begin
      step();
      k++;
    end
    check("reach_await", m_active, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_cs", cs_n, 1);
    check("rst2_wr", wr_n, 1);
    check("rst2_level", level, 0);
    check("rst2_busy", busy, 0);
    strobes = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (!cs_n) strobes++;
    end
    check("rst2_no_strobe", strobes, 0);

    // Enable stall during the data strobe.
    mode = 3;
    push(8'h07, 8'h3C);
    k = 0;
    while (!(m_active && m_n >= WrPulse + AddrWait) && k < 200) begin
      step();
      k++;
    end
    mode = 1;
    for (int i = 0; i < 50; i++) begin
      step();
      check("stall_wr", wr_n, 0);
      check("stall_d", d, 8'h3C);
    end
    mode = 3;
    run_until_idle(500, "stall_done");

    // Random traffic with random enables and rare resets.
    mode = 2;
    for (int i = 0; i < 4000; i++) begin
      wr_valid = (($urandom % 8) == 0);
      wr_addr  = 8'($urandom);
      wr_data  = 8'($urandom);
      rst      = (($urandom % 1000) == 0);
      step();
    end
    wr_valid = 1'b0;
    rst      = 1'b0;
    run_until_idle(20000, "random_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
